// File: rtl/gactx_bank3_pkg.sv
// Purpose: shared types and constants for the bank-3 sequence unpacker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default slice geometry, index-width helper.
package gactx_bank3_pkg;

    // Default geometry: a 512-bit read beat split into 16 slices of 4 bytes.
    localparam int N_SLICES    = 16;
    localparam int SLICE_BYTES = 4;
    localparam int LEN_WIDTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of a slice index; never zero, even for a single-slice beat.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gactx_bank3_seq_unpacker.sv
// Purpose: split wide read beats into narrow, byte-counted slices for the GACT-X array.
// Latency: first slice valid the cycle after its beat is accepted; one slice per cycle after that.
// Backpressure: m_axis_tready stalls hold outputs stable; s_axis_tready only opens when the hold register frees.
//
// Ports:
//   aclk, areset                  clock, asynchronous active-high reset
//   ctrl_start / ctrl_len_bytes   job start pulse and byte count (sampled only in IDLE)
//   ctrl_done / ctrl_short        one-cycle completion pulse, sticky "input ended early" flag
//   s_axis_*                      wide input beats (tvalid/tready/tdata/tlast)
//   m_axis_*                      narrow output slices (tvalid/tready/tdata/tkeep/tlast)
module gactx_bank3_seq_unpacker
    import gactx_bank3_pkg::*;
#(
    parameter int C_IN_WIDTH  = N_SLICES * SLICE_BYTES * 8,
    parameter int C_OUT_WIDTH = SLICE_BYTES * 8,
    parameter int C_LEN_WIDTH = LEN_WIDTH
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     ctrl_start,
    input  logic [C_LEN_WIDTH-1:0]   ctrl_len_bytes,
    output logic                     ctrl_done,
    output logic                     ctrl_short,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [C_IN_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [C_OUT_WIDTH-1:0]   m_axis_tdata,
    output logic [C_OUT_WIDTH/8-1:0] m_axis_tkeep,
    output logic                     m_axis_tlast
);

    localparam int NSL   = C_IN_WIDTH / C_OUT_WIDTH;
    localparam int SLB   = C_OUT_WIDTH / 8;
    localparam int IDX_W = idx_width(NSL);

    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NSL - 1);
    localparam logic [C_LEN_WIDTH-1:0] SLB_LEN  = C_LEN_WIDTH'(SLB);

    state_t                   state_q;
    state_t                   state_d;
    logic [C_IN_WIDTH-1:0]    hold_q;
    logic                     hold_vld_q;
    logic                     hold_last_q;
    logic [IDX_W-1:0]         idx_q;
    logic [C_LEN_WIDTH-1:0]   remaining_q;
    logic                     short_q;

    logic                     start_acc;
    logic                     slice_hs;
    logic                     beat_hs;
    logic                     last_idx;
    logic                     len_end;
    logic                     end_slice;
    logic                     short_end;
    logic [C_LEN_WIDTH-1:0]   dec;
    logic [C_OUT_WIDTH-1:0]   slice_arr [NSL];

    // Slice view of the hold register; slice 0 carries the lowest bytes.
    for (genvar g = 0; g < NSL; g++) begin : g_slice
        assign slice_arr[g] = hold_q[g*C_OUT_WIDTH +: C_OUT_WIDTH];
    end

    assign last_idx  = (idx_q == IDX_LAST);
    assign len_end   = (remaining_q <= SLB_LEN);
    // The job ends either when the byte count runs out or when the last
    // slice of the final input beat goes out with bytes still owed.
    assign end_slice = len_end || (hold_last_q && last_idx);
    assign short_end = hold_last_q && last_idx && !len_end;
    // min(slice bytes, remaining) keeps the counter from wrapping below zero.
    assign dec       = len_end ? remaining_q : SLB_LEN;

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        ctrl_done     = 1'b0;
        start_acc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    start_acc = 1'b1;
                    state_d   = (ctrl_len_bytes == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                m_axis_tvalid = hold_vld_q;
                // Refill in the same cycle the last slice of a beat leaves,
                // unless that slice also ends the job.
                s_axis_tready = !hold_vld_q ||
                                (m_axis_tready && last_idx && !end_slice);
                if (hold_vld_q && m_axis_tready && end_slice) begin
                    state_d = hold_last_q ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ctrl_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign slice_hs = m_axis_tvalid && m_axis_tready;
    assign beat_hs  = (state_q == ST_RUN) && s_axis_tvalid && s_axis_tready;

    // Hold register, slice index, byte counter and short flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            hold_last_q <= 1'b0;
            idx_q       <= '0;
            remaining_q <= '0;
            short_q     <= 1'b0;
        end else begin
            if (start_acc) begin
                remaining_q <= ctrl_len_bytes;
                short_q     <= 1'b0;
                idx_q       <= '0;
                hold_vld_q  <= 1'b0;
            end
            if (slice_hs) begin
                remaining_q <= remaining_q - dec;
                if (end_slice || last_idx) begin
                    idx_q      <= '0;
                    hold_vld_q <= 1'b0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
                if (short_end) begin
                    short_q <= 1'b1;
                end
            end
            // A beat accepted alongside the final slice re-arms the hold.
            if (beat_hs) begin
                hold_q      <= s_axis_tdata;
                hold_last_q <= s_axis_tlast;
                hold_vld_q  <= 1'b1;
            end
        end
    end

    assign m_axis_tdata = slice_arr[idx_q];
    assign m_axis_tlast = m_axis_tvalid && end_slice;
    assign ctrl_short   = short_q;

    always_comb begin
        m_axis_tkeep = '0;
        for (int k = 0; k < SLB; k++) begin
            m_axis_tkeep[k] = m_axis_tvalid && (remaining_q > C_LEN_WIDTH'(k));
        end
    end

endmodule

// File: tb/tb_gactx_bank3_seq_unpacker.sv
// Purpose: directed self-checking bench for gactx_bank3_seq_unpacker.
// Latency: n/a (testbench).
// Backpressure: drives random sink stalls and source gaps in one job.
module tb_gactx_bank3_seq_unpacker;

    localparam int IW = 512;
    localparam int OW = 32;
    localparam int LW = 32;

    logic            aclk = 1'b0;
    logic            areset;
    logic            ctrl_start;
    logic [LW-1:0]   ctrl_len_bytes;
    logic            ctrl_done;
    logic            ctrl_short;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [IW-1:0]   s_axis_tdata;
    logic            s_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [OW-1:0]   m_axis_tdata;
    logic [OW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast;

    always #5 aclk = ~aclk;

    gactx_bank3_seq_unpacker #(
        .C_IN_WIDTH  (IW),
        .C_OUT_WIDTH (OW),
        .C_LEN_WIDTH (LW)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .ctrl_start     (ctrl_start),
        .ctrl_len_bytes (ctrl_len_bytes),
        .ctrl_done      (ctrl_done),
        .ctrl_short     (ctrl_short),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source beat queue and traffic shaping knobs.
    logic [IW-1:0] bq_dat [$];
    bit            bq_last [$];
    bit            gap_en;
    bit            stall_en;

    // Monitor records.
    int          cyc = 0;
    logic [31:0] sl_dat  [$];
    logic [3:0]  sl_keep [$];
    bit          sl_last [$];
    int          sl_cyc  [$];
    int          acc_cyc [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          done_prev = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_dat;
    logic [3:0]  prev_keep;
    logic        prev_last;

    // Source driver: holds a presented beat until accepted.
    initial begin : s_drv
        bit acc;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        forever begin
            @(negedge aclk);
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            if (acc && bq_dat.size() > 0) begin
                void'(bq_dat.pop_front());
                void'(bq_last.pop_front());
            end
            if (bq_dat.size() > 0 &&
                (s_axis_tvalid || !gap_en || $urandom_range(0, 2) == 0)) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = bq_dat[0];
                s_axis_tlast  = bq_last[0];
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    // Sink ready driver.
    initial begin : m_drv
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, records handshakes, checks stall stability.
    initial begin : mon
        forever begin
            @(negedge aclk);
            cyc++;
            if (stall_prev && !areset) begin
                chk("stall_vld",  m_axis_tvalid, 1'b1);
                chk("stall_dat",  m_axis_tdata,  prev_dat);
                chk("stall_keep", m_axis_tkeep,  prev_keep);
                chk("stall_last", m_axis_tlast,  prev_last);
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
            prev_keep  = m_axis_tkeep;
            prev_last  = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                sl_dat.push_back(m_axis_tdata);
                sl_keep.push_back(m_axis_tkeep);
                sl_last.push_back(m_axis_tlast);
                sl_cyc.push_back(cyc);
            end
            if (s_axis_tvalid && s_axis_tready) begin
                acc_cyc.push_back(cyc);
            end
            if (ctrl_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_one_cycle", done_prev, 1'b0);
            end
            done_prev = ctrl_done;
        end
    end

    // Beat b byte i = seed + 64*b + i, so the stream is a running byte count.
    task automatic load_beats(input int nbeats, input int seed);
        for (int b = 0; b < nbeats; b++) begin
            logic [IW-1:0] d;
            for (int i = 0; i < IW/8; i++) begin
                d[8*i +: 8] = 8'(seed + 64*b + i);
            end
            bq_dat.push_back(d);
            bq_last.push_back(b == nbeats - 1);
        end
    endtask

    task automatic clear_mon();
        sl_dat.delete();
        sl_keep.delete();
        sl_last.delete();
        sl_cyc.delete();
        acc_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic start_job(input int len);
        @(posedge aclk);
        #1;
        ctrl_start     = 1'b1;
        ctrl_len_bytes = LW'(len);
        @(posedge aclk);
        #1;
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(posedge aclk);
        end
        repeat (3) @(posedge aclk);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    // Expected slices from the byte count and the beats supplied.
    task automatic check_stream(input string tag, input int len, input int nbeats, input int seed);
        int avail;
        bit short_e;
        int nsl;
        avail   = nbeats * 64;
        short_e = (len > avail);
        nsl     = short_e ? avail / 4 : (len + 3) / 4;
        chk({tag, "_nslices"}, sl_dat.size(), nsl);
        for (int j = 0; j < nsl && j < sl_dat.size(); j++) begin
            logic [31:0] ed;
            logic [3:0]  ek;
            int          rem;
            for (int b = 0; b < 4; b++) ed[8*b +: 8] = 8'(seed + 4*j + b);
            rem = len - 4*j;
            for (int k = 0; k < 4; k++) ek[k] = (rem > k);
            chk($sformatf("%s_dat%0d", tag, j),  sl_dat[j],  ed);
            chk($sformatf("%s_keep%0d", tag, j), sl_keep[j], ek);
            chk($sformatf("%s_last%0d", tag, j), sl_last[j], (j == nsl - 1));
        end
        chk({tag, "_short"}, ctrl_short, short_e);
    endtask

    initial begin : main
        areset         = 1'b1;
        ctrl_start     = 1'b0;
        ctrl_len_bytes = '0;
        gap_en         = 1'b0;
        stall_en       = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tlast",  m_axis_tlast,  1'b0);
        chk("rst_m_tkeep",  m_axis_tkeep,  4'h0);
        chk("rst_m_tdata",  m_axis_tdata,  32'h0);
        chk("rst_done",     ctrl_done,     1'b0);
        chk("rst_short",    ctrl_short,    1'b0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (2) @(posedge aclk);

        // One full beat, exact length.
        clear_mon();
        load_beats(1, 0);
        start_job(64);
        wait_done("t1", 200);
        check_stream("t1", 64, 1, 0);
        if (sl_dat.size() >= 16 && acc_cyc.size() >= 1) begin
            chk("t1_first",    sl_dat[0], 32'h03020100);
            chk("t1_latency",  sl_cyc[0] - acc_cyc[0], 1);
            chk("t1_done_gap", done_cyc - sl_cyc[15], 1);
        end

        // Two beats, job ends mid-beat.
        clear_mon();
        load_beats(2, 8'h10);
        start_job(70);
        wait_done("t2", 200);
        check_stream("t2", 70, 2, 8'h10);
        chk("t2_beats", acc_cyc.size(), 2);
        if (sl_dat.size() >= 18) begin
            chk("t2_keep17",    sl_keep[17], 4'h3);
            chk("t2_no_bubble", sl_cyc[17] - sl_cyc[0], 17);
        end

        // Length satisfied by first beat; remaining beats flushed.
        clear_mon();
        load_beats(3, 8'h20);
        start_job(64);
        wait_done("t3", 200);
        check_stream("t3", 64, 3, 8'h20);
        chk("t3_beats", acc_cyc.size(), 3);
        if (acc_cyc.size() >= 3) begin
            chk("t3_done_gap", done_cyc - acc_cyc[2], 1);
        end

        // Input ends early.
        clear_mon();
        load_beats(1, 8'h30);
        start_job(128);
        wait_done("t4", 200);
        check_stream("t4", 128, 1, 8'h30);

        // Random stalls and gaps, plus a start pulse mid-job that must be ignored.
        clear_mon();
        stall_en = 1'b1;
        gap_en   = 1'b1;
        load_beats(4, 8'h55);
        start_job(256);
        for (int i = 0; i < 400 && sl_dat.size() < 10; i++) @(posedge aclk);
        #1;
        ctrl_start     = 1'b1;
        ctrl_len_bytes = LW'(4);
        @(posedge aclk);
        #1;
        ctrl_start = 1'b0;
        wait_done("t5", 2000);
        check_stream("t5", 256, 4, 8'h55);
        stall_en = 1'b0;
        gap_en   = 1'b0;
        repeat (2) @(posedge aclk);

        // Reset mid-transfer.
        clear_mon();
        load_beats(2, 8'h40);
        start_job(128);
        for (int i = 0; i < 400 && sl_dat.size() < 7; i++) @(posedge aclk);
        #1;
        areset = 1'b1;
        #1;
        chk("t6_s_tready", s_axis_tready, 1'b0);
        chk("t6_m_tvalid", m_axis_tvalid, 1'b0);
        chk("t6_m_tlast",  m_axis_tlast,  1'b0);
        chk("t6_m_tkeep",  m_axis_tkeep,  4'h0);
        chk("t6_m_tdata",  m_axis_tdata,  32'h0);
        chk("t6_short",    ctrl_short,    1'b0);
        bq_dat.delete();
        bq_last.delete();
        repeat (4) @(posedge aclk);
        chk("t6_slices_seen", sl_dat.size(), 7);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (3) @(posedge aclk);
        chk("t6_no_done", done_cnt, 0);

        // Short job after reset.
        clear_mon();
        load_beats(1, 8'h80);
        start_job(4);
        wait_done("t7", 200);
        check_stream("t7", 4, 1, 8'h80);
        if (sl_keep.size() >= 1) begin
            chk("t7_keep0", sl_keep[0], 4'hF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gactx_bank3_seq_unpacker.md
GACTX_BANK3_SEQ_UNPACKER -- requirements
Module: gactx_bank3_seq_unpacker

Interface
REQ-001 SHALL have parameter C_IN_WIDTH, default 512, input stream data width in bits.
REQ-002 SHALL have parameter C_OUT_WIDTH, default 32, output slice width in bits; C_IN_WIDTH/C_OUT_WIDTH = N_SLICES (default 16).
REQ-003 SHALL have parameter C_LEN_WIDTH, default 32, width of byte-length field.
REQ-004 SHALL have port aclk  in  1  single clock for all logic.
REQ-005 SHALL have port areset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port ctrl_start  in  1  one-cycle start pulse.
REQ-007 SHALL have port ctrl_len_bytes  in  C_LEN_WIDTH  number of bytes to emit; sampled on ctrl_start.
REQ-008 SHALL have port ctrl_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port ctrl_short  out  1  sticky flag: input ended before ctrl_len_bytes emitted.
REQ-010 SHALL have ports s_axis_tvalid/in/1, s_axis_tready/out/1, s_axis_tdata/in/C_IN_WIDTH, s_axis_tlast/in/1: wide beats from the read master.
REQ-011 SHALL have ports m_axis_tvalid/out/1, m_axis_tready/in/1, m_axis_tdata/out/C_OUT_WIDTH, m_axis_tkeep/out/C_OUT_WIDTH/8, m_axis_tlast/out/1: sequence slices to the GACT-X array.

Function
REQ-012 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-013 IDLE: s_axis_tready=0, m_axis_tvalid=0; on ctrl_start latch ctrl_len_bytes into remaining counter, clear ctrl_short, go RUN (len=0: go DONE directly).
REQ-014 ctrl_start outside IDLE SHALL be ignored.
REQ-015 RUN: one holding register (C_IN_WIDTH bits + valid bit) and slice index 0..N_SLICES-1.
REQ-016 s_axis_tready SHALL be high when hold empty, or when the slice being accepted this cycle is the final slice of the held beat (back-to-back, zero bubble).
REQ-017 Latency: m_axis_tvalid SHALL assert the cycle after an input beat is accepted; throughput one slice per cycle with m_axis_tready held high.
REQ-018 m_axis_tdata SHALL equal hold[idx*C_OUT_WIDTH +: C_OUT_WIDTH]; slice 0 = least-significant bytes.
REQ-019 m_axis_tkeep bit k SHALL be 1 iff remaining > k; m_axis_tlast SHALL be 1 iff remaining <= C_OUT_WIDTH/8.
REQ-020 On slice handshake: remaining -= min(C_OUT_WIDTH/8, remaining); idx increments, wrapping to 0 and freeing hold after slice N_SLICES-1.
REQ-021 m_axis_tdata/tkeep/tlast SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 After the tlast slice handshake: if held beat carried s_axis_tlast go DONE, else go FLUSH; unused slices of held beat discarded.
REQ-023 FLUSH: s_axis_tready=1, m_axis_tvalid=0; discard beats until a beat with s_axis_tlast is accepted, then DONE.
REQ-024 Short input: if final slice of a beat with s_axis_tlast is handshaken while remaining > slice bytes, that slice SHALL carry m_axis_tlast=1, ctrl_short SHALL set, state SHALL go DONE.
REQ-025 DONE: ctrl_done=1 for exactly one cycle, then IDLE; ctrl_short holds until next accepted ctrl_start.
REQ-026 remaining counter SHALL never underflow; arithmetic unsigned, C_LEN_WIDTH bits.

Reset
REQ-027 areset SHALL asynchronously force state IDLE, hold invalid, idx=0, remaining=0.
REQ-028 During reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, ctrl_done=0, ctrl_short=0; m_axis_tdata=0.
REQ-029 Reset mid-transfer SHALL abandon the job with no ctrl_done pulse; first cycle after deassertion is IDLE.

Structure
REQ-030 State enum and localparams N_SLICES, SLICE_BYTES SHALL live in shared package gactx_bank3_pkg.
REQ-031 No sub-module required; holding register, index and remaining counter are inline in one module.

Verification
REQ-032 len=64, one beat bytes 0x00..0x3F with tlast, tready=1 -> 16 slices, first 0x03020100, tkeep=0xF all, tlast on 16th, ctrl_done 1 cycle later.
REQ-033 len=70, two beats (second tlast) -> 18 slices, slice 18 tkeep=0x3, tlast=1; remaining 14 slices discarded; ctrl_short=0.
REQ-034 len=64, three beats, last with tlast -> 16 slices, FLUSH accepts beats 2-3, ctrl_done after beat 3 accepted.
REQ-035 len=128, one beat with tlast -> 16 slices, tlast on slice 16, ctrl_short=1, ctrl_done pulse.
REQ-036 len=256, random m_axis_tready stalls and s_axis_tvalid gaps -> data stable during stalls, zero-bubble at beat boundary when unstalled, byte stream matches input.
REQ-037 areset asserted at slice 7 of len=128 job -> outputs zero immediately, no ctrl_done; subsequent len=4 job completes with one slice, tkeep=0xF.
